arbitro_barramento: RTL and testbench



---
 rtl/arbitro_barramento_if.sv | 33 +++
 rtl/arbitro_barramento.sv | 151 +++++++++++++++
 tb/tb_arbitro_barramento.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/arbitro_barramento_if.sv
// Interface bundling the arbitration handshake between the requesting units
// and arbitro_barramento.
//   requisicao [3:0] : bit i high = requester i wants or keeps the bus
//   concessao  [3:0] : one-hot grant, zero when the bus is free
//   M          [1:0] : multiplexer selector, index of current or last owner
//   ocupado          : high while any grant is active
//   preempcao        : one-cycle pulse on a forced release
// Modports:
//   master : requester side (drives requisicao, observes the rest)
//   slave  : arbiter side (observes requisicao, drives the rest)
interface arbitro_barramento_if;
  logic [3:0] requisicao;
  logic [3:0] concessao;
  logic [1:0] M;
  logic       ocupado;
  logic       preempcao;

  modport master (
    output requisicao,
    input  concessao,
    input  M,
    input  ocupado,
    input  preempcao
  );

  modport slave (
    input  requisicao,
    output concessao,
    output M,
    output ocupado,
    output preempcao
  );
endinterface

// File: rtl/arbitro_barramento.sv
// Round-robin arbiter for the four requesters sharing the 16-bit 4x1 datapath
// multiplexer. Issues one-hot grants, drives the mux selector M and limits
// how long one owner may keep the bus while another requester waits.
// Ports:
//   clock      : system clock, rising edge
//   reset      : asynchronous, active-high reset
//   barramento : arbitro_barramento_if.slave (requisicao in; concessao, M,
//                ocupado, preempcao out; all outputs registered)
// Parameter:
//   MAX_POSSE  : maximum consecutive granted cycles while another requester
//                is waiting (1..255)
module arbitro_barramento #(
  parameter int unsigned MAX_POSSE = 8
) (
  input logic                  clock,
  input logic                  reset,
  arbitro_barramento_if.slave  barramento
);

  typedef enum logic {
    LIVRE,
    CONCEDIDO
  } estado_t;

  localparam logic [7:0] LP_MAX = 8'(MAX_POSSE);

  estado_t    r_estado;
  logic [1:0] r_ptr;
  logic [7:0] r_cnt;
  logic [3:0] r_concessao;
  logic [1:0] r_M;
  logic       r_ocupado;
  logic       r_preempcao;

  estado_t    w_estado_prox;
  logic [1:0] w_ptr_prox;
  logic [7:0] w_cnt_prox;
  logic [3:0] w_concessao_prox;
  logic [1:0] w_M_prox;
  logic       w_ocupado_prox;
  logic       w_preempcao_prox;

  logic [3:0] w_req;
  logic [1:0] w_vencedor;
  logic [3:0] w_dono_oh;
  logic       w_outros_esperam;

  function automatic logic [3:0] f_onehot(input logic [1:0] idx);
    logic [3:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // First set request bit scanning ptr, ptr+1, ... modulo 4.
  function automatic logic [1:0] f_varredura(input logic [3:0] req,
                                             input logic [1:0] ptr);
    logic [1:0] idx;
    logic [1:0] venc;
    logic       achou;
    venc  = ptr;
    achou = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!achou && req[idx]) begin
        venc  = idx;
        achou = 1'b1;
      end
    end
    return venc;
  endfunction

  assign w_req            = barramento.requisicao;
  assign w_vencedor       = f_varredura(w_req, r_ptr);
  // While CONCEDIDO, r_M always holds the current owner's index.
  assign w_dono_oh        = f_onehot(r_M);
  assign w_outros_esperam = |(w_req & ~w_dono_oh);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado    <= LIVRE;
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_concessao <= '0;
      r_M         <= '0;
      r_ocupado   <= 1'b0;
      r_preempcao <= 1'b0;
    end else begin
      r_estado    <= w_estado_prox;
      r_ptr       <= w_ptr_prox;
      r_cnt       <= w_cnt_prox;
      r_concessao <= w_concessao_prox;
      r_M         <= w_M_prox;
      r_ocupado   <= w_ocupado_prox;
      r_preempcao <= w_preempcao_prox;
    end
  end

  always_comb begin
    w_estado_prox    = r_estado;
    w_ptr_prox       = r_ptr;
    w_cnt_prox       = r_cnt;
    w_concessao_prox = r_concessao;
    w_M_prox         = r_M;
    w_ocupado_prox   = r_ocupado;
    w_preempcao_prox = 1'b0;

    unique case (r_estado)
      LIVRE: begin
        if (|w_req) begin
          w_concessao_prox = f_onehot(w_vencedor);
          w_M_prox         = w_vencedor;
          w_ocupado_prox   = 1'b1;
          w_cnt_prox       = 8'd1;
          w_estado_prox    = CONCEDIDO;
        end
      end

      CONCEDIDO: begin
        // Voluntary release is checked first so that a simultaneous drop
        // at the hold limit never raises preempcao.
        if (!w_req[r_M] || (r_cnt == LP_MAX && w_outros_esperam)) begin
          w_concessao_prox = '0;
          w_ocupado_prox   = 1'b0;
          w_estado_prox    = LIVRE;
          w_ptr_prox       = r_M + 2'd1;
          w_cnt_prox       = '0;
          w_preempcao_prox = w_req[r_M];
        end else if (r_cnt != LP_MAX) begin
          w_cnt_prox = r_cnt + 8'd1;
        end
      end

      default: begin
        w_estado_prox = LIVRE;
      end
    endcase
  end

  assign barramento.concessao = r_concessao;
  assign barramento.M         = r_M;
  assign barramento.ocupado   = r_ocupado;
  assign barramento.preempcao = r_preempcao;

  a_grant_onehot: assert property (@(posedge clock) disable iff (reset)
    $onehot0(r_concessao));

  a_ocupado_coerente: assert property (@(posedge clock) disable iff (reset)
    r_ocupado == (|r_concessao));

endmodule

// File: tb/tb_arbitro_barramento.sv
module tb_arbitro_barramento;

  logic clock;
  logic reset;

  arbitro_barramento_if arb_if ();

  arbitro_barramento #(.MAX_POSSE(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .barramento (arb_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_total = 0;
  int n_pass  = 0;
  int n_ciclo = 0;

  // Expected packed as {concessao, M, ocupado, preempcao}.
  logic [8:0] sb_q[$];

  task automatic check_vec(input string nome, input logic [8:0] act,
                           input logic [8:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got conc=%b M=%0d ocup=%b preemp=%b, expected conc=%b M=%0d ocup=%b preemp=%b",
               nome, act[8:5], act[4:3], act[2], act[1],
               exp[8:5], exp[4:3], exp[2], exp[1]);
    end
  endtask

  function automatic logic [8:0] amostra();
    return {arb_if.concessao, arb_if.M, arb_if.ocupado, arb_if.preempcao, 1'b0};
  endfunction

  // Monitor: one expected entry per clock edge, sampled 1 time unit later.
  always @(posedge clock) begin
    #1;
    if (sb_q.size() > 0) begin
      logic [8:0] e;
      e = sb_q.pop_front();
      n_ciclo++;
      check_vec($sformatf("ciclo_%0d", n_ciclo), amostra(), e);
    end
  end

  // Drive req for the next edge and record the outputs expected after it.
  task automatic step(input logic [3:0] req, input logic [3:0] c,
                      input logic [1:0] m, input logic p);
    @(negedge clock);
    arb_if.requisicao = req;
    sb_q.push_back({c, m, |c, p, 1'b0});
  endtask

  task automatic do_reset(input string nome);
    @(negedge clock);
    reset = 1'b1;
    arb_if.requisicao = 4'b0000;
    #1;
    check_vec(nome, amostra(), 9'b0);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] oh;
    logic [3:0] todos;
    reset = 1'b1;
    arb_if.requisicao = 4'b0000;
    #1;
    check_vec("reset_inicial", amostra(), 9'b0);
    #7;
    reset = 1'b0;

    // 1: single request, release, idle hold
    step(4'b0001, 4'b0001, 2'd0, 1'b0);
    step(4'b0000, 4'b0000, 2'd0, 1'b0);
    step(4'b0000, 4'b0000, 2'd0, 1'b0);

    // 2: full rotation with all four requesting
    do_reset("reset_t2");
    todos = 4'b1111;
    for (int g = 0; g < 4; g++) begin
      oh = 4'b0001 << g;
      step(todos, oh, 2'(g), 1'b0);
      step(todos, oh, 2'(g), 1'b0);
      step(todos & ~oh, 4'b0000, 2'(g), 1'b0);
    end
    step(4'b1111, 4'b0001, 2'd0, 1'b0);
    step(4'b1110, 4'b0000, 2'd0, 1'b0);

    // 3: forced hand-over after 8 cycles
    do_reset("reset_t3");
    step(4'b0001, 4'b0001, 2'd0, 1'b0);
    step(4'b0001, 4'b0001, 2'd0, 1'b0);
    step(4'b0001, 4'b0001, 2'd0, 1'b0);
    for (int i = 0; i < 5; i++) step(4'b0101, 4'b0001, 2'd0, 1'b0);
    step(4'b0101, 4'b0000, 2'd0, 1'b1);
    step(4'b0101, 4'b0100, 2'd2, 1'b0);
    step(4'b0001, 4'b0000, 2'd2, 1'b0);
    step(4'b0001, 4'b0001, 2'd0, 1'b0);
    step(4'b0000, 4'b0000, 2'd0, 1'b0);

    // 3b: owner drops exactly at the hold limit with another waiting
    do_reset("reset_t3b");
    step(4'b0010, 4'b0010, 2'd1, 1'b0);
    for (int i = 0; i < 7; i++) step(4'b0011, 4'b0010, 2'd1, 1'b0);
    step(4'b0001, 4'b0000, 2'd1, 1'b0);
    step(4'b0001, 4'b0001, 2'd0, 1'b0);
    step(4'b0000, 4'b0000, 2'd0, 1'b0);

    // 4: lone requester held 20 cycles, never preempted
    do_reset("reset_t4");
    for (int i = 0; i < 20; i++) step(4'b0010, 4'b0010, 2'd1, 1'b0);
    step(4'b0000, 4'b0000, 2'd1, 1'b0);

    // 5: wrap-around from ptr=3
    do_reset("reset_t5");
    step(4'b0100, 4'b0100, 2'd2, 1'b0);
    step(4'b0000, 4'b0000, 2'd2, 1'b0);
    step(4'b0101, 4'b0001, 2'd0, 1'b0);
    step(4'b0000, 4'b0000, 2'd0, 1'b0);

    // 6: asynchronous reset in the middle of requester 3's grant
    do_reset("reset_t6");
    step(4'b1000, 4'b1000, 2'd3, 1'b0);
    step(4'b1000, 4'b1000, 2'd3, 1'b0);
    @(posedge clock);
    #2;
    reset = 1'b1;
    arb_if.requisicao = 4'b0000;
    #1;
    check_vec("reset_assincrono", amostra(), 9'b0);
    #1;
    reset = 1'b0;
    step(4'b1001, 4'b0001, 2'd0, 1'b0);
    step(4'b0000, 4'b0000, 2'd0, 1'b0);

    repeat (4) @(posedge clock);
    #2;
    n_total++;
    if (sb_q.size() == 0) begin
      n_pass++;
    end else begin
      $display("FAIL fila_vazia: got %0d pending, expected 0", sb_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
